pipeline_flush_ctrl: RTL and testbench

Hazard and flush controller for the multicycle/pipelined MIPS datapath: it drives the `FlushRegisters` inputs of the inter-stage delay registers and the stall enables of the PC and IF/ID register. It detects load-use hazards, taken branches, jumps and exceptions, and sequences the required bubble and flush cycles with a small state machine. The controller updates on the rising edge so its outputs are stable before the pipeline registers sample on the falling edge.

---
 rtl/pipeline_flush_ctrl.sv | 118 +++++++++++
 tb/tb_pipeline_flush_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pipeline_flush_ctrl.sv
// Hazard and flush controller for the pipelined MIPS datapath.
//
// Drives the FlushRegisters inputs of the inter-stage registers and the stall
// enables of the PC and IF/ID register. State updates on the rising edge, so the
// outputs are settled before the pipeline registers sample on the falling edge.
//
// Ports:
//   clk, Reset                 clock, asynchronous active-high reset
//   ID_Rs, ID_Rt               source specifiers of the instruction in ID
//   EX_Rt, EX_MemRead          destination specifier / load flag of the instruction in EX
//   BranchTaken, Jump          control-flow redirects (branch in EX, jump in ID)
//   Exception                  exception raised in EX/MEM
//   StallPC, StallIF_ID        hold the PC / IF/ID register
//   FlushIF_ID/ID_EX/EX_MEM    flush controls for the inter-stage registers
//   ExceptionAck               one-cycle acknowledge of an accepted exception
module pipeline_flush_ctrl #(
    parameter int unsigned BRANCH_FLUSH_CYCLES = 2,
    parameter int unsigned REG_W               = 5
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic [REG_W-1:0] EX_Rt,
    input  logic             EX_MemRead,
    input  logic             BranchTaken,
    input  logic             Jump,
    input  logic             Exception,
    output logic             StallPC,
    output logic             StallIF_ID,
    output logic             FlushIF_ID,
    output logic             FlushID_EX,
    output logic             FlushEX_MEM,
    output logic             ExceptionAck
);

    typedef enum logic [2:0] {
        StRun    = 3'd0,
        StStall  = 3'd1,
        StBflush = 3'd2,
        StJflush = 3'd3,
        StExc    = 3'd4
    } state_e;

    // The counter holds the number of BFLUSH cycles still to come after this one.
    localparam logic [2:0] CntLoad = 3'(BRANCH_FLUSH_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       load_use;

    // r0 is hard-wired zero, so a load targeting it can never create a hazard.
    assign load_use = EX_MemRead && (EX_Rt != '0) && ((EX_Rt == ID_Rs) || (EX_Rt == ID_Rt));

    // State register
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= StRun;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic, first match wins
    always_comb begin
        state_d = StRun;
        cnt_d   = 3'd0;
        if (Exception) begin
            state_d = StExc;
        end else if (BranchTaken) begin
            state_d = StBflush;
            cnt_d   = CntLoad;
        end else if (state_q == StBflush && cnt_q != 3'd0) begin
            // ID holds flushed garbage here, so Jump and load-use are not looked at.
            state_d = StBflush;
            cnt_d   = cnt_q - 3'd1;
        end else if (Jump) begin
            state_d = StJflush;
        end else if (load_use && state_q != StStall) begin
            // One bubble resolves the hazard; the same load must not stall twice.
            state_d = StStall;
        end
    end

    // Output decode
    always_comb begin
        StallPC      = 1'b0;
        StallIF_ID   = 1'b0;
        FlushIF_ID   = 1'b0;
        FlushID_EX   = 1'b0;
        FlushEX_MEM  = 1'b0;
        ExceptionAck = 1'b0;
        unique case (state_q)
            StStall: begin
                StallPC    = 1'b1;
                StallIF_ID = 1'b1;
                FlushID_EX = 1'b1;
            end
            StBflush: begin
                FlushIF_ID = 1'b1;
                FlushID_EX = 1'b1;
            end
            StJflush: begin
                FlushIF_ID = 1'b1;
            end
            StExc: begin
                FlushIF_ID   = 1'b1;
                FlushID_EX   = 1'b1;
                FlushEX_MEM  = 1'b1;
                ExceptionAck = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pipeline_flush_ctrl.sv
// Directed bench for pipeline_flush_ctrl: two instances (2 and 4 branch-flush
// cycles) share the stimulus; outputs are packed as
// {StallPC, StallIF_ID, FlushIF_ID, FlushID_EX, FlushEX_MEM, ExceptionAck}.
module tb_pipeline_flush_ctrl;

    localparam logic [5:0] ORun   = 6'b000000;
    localparam logic [5:0] OStall = 6'b110100;
    localparam logic [5:0] OBfl   = 6'b001100;
    localparam logic [5:0] OJfl   = 6'b001000;
    localparam logic [5:0] OExc   = 6'b001111;

    logic       clk = 1'b0;
    logic       Reset;
    logic [4:0] ID_Rs, ID_Rt, EX_Rt;
    logic       EX_MemRead, BranchTaken, Jump, Exception;

    logic a_spc, a_sif, a_fif, a_fid, a_fex, a_ack;
    logic b_spc, b_sif, b_fif, b_fid, b_fex, b_ack;
    logic [5:0] out_a, out_b;

    int total = 0;
    int bad   = 0;

    assign out_a = {a_spc, a_sif, a_fif, a_fid, a_fex, a_ack};
    assign out_b = {b_spc, b_sif, b_fif, b_fid, b_fex, b_ack};

    always #5 clk = ~clk;

    pipeline_flush_ctrl #(.BRANCH_FLUSH_CYCLES(2), .REG_W(5)) u_dut2 (
        .clk(clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .EX_Rt(EX_Rt),
        .EX_MemRead(EX_MemRead), .BranchTaken(BranchTaken), .Jump(Jump),
        .Exception(Exception), .StallPC(a_spc), .StallIF_ID(a_sif),
        .FlushIF_ID(a_fif), .FlushID_EX(a_fid), .FlushEX_MEM(a_fex), .ExceptionAck(a_ack)
    );

    pipeline_flush_ctrl #(.BRANCH_FLUSH_CYCLES(4), .REG_W(5)) u_dut4 (
        .clk(clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .EX_Rt(EX_Rt),
        .EX_MemRead(EX_MemRead), .BranchTaken(BranchTaken), .Jump(Jump),
        .Exception(Exception), .StallPC(b_spc), .StallIF_ID(b_sif),
        .FlushIF_ID(b_fif), .FlushID_EX(b_fid), .FlushEX_MEM(b_fex), .ExceptionAck(b_ack)
    );

    task automatic check_val(input string tag, input logic [5:0] got, input logic [5:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ID_Rs = 5'd0; ID_Rt = 5'd0; EX_Rt = 5'd0;
        EX_MemRead = 1'b0; BranchTaken = 1'b0; Jump = 1'b0; Exception = 1'b0;
    endtask

    initial begin
        idle();
        Reset = 1'b1;
        #1;
        check_val("reset_a", out_a, ORun);
        check_val("reset_b", out_b, ORun);
        @(negedge clk);
        Reset = 1'b0;
        tick();
        check_val("post_reset", out_a, ORun);

        // Load-use via rs, held two cycles: exactly one stall
        EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
        tick(); check_val("lu_stall", out_a, OStall);
        tick(); check_val("lu_no_restall", out_a, ORun);
        idle();
        tick(); check_val("lu_after", out_a, ORun);

        // Load into r0: no hazard
        EX_MemRead = 1'b1; EX_Rt = 5'd0; ID_Rs = 5'd0;
        tick(); check_val("lu_r0_1", out_a, ORun);
        tick(); check_val("lu_r0_2", out_a, ORun);

        // Load-use via rt
        EX_Rt = 5'd3; ID_Rs = 5'd1; ID_Rt = 5'd3;
        tick(); check_val("lu_rt", out_a, OStall);
        idle();
        // Non-load matching register: no stall
        EX_Rt = 5'd3; ID_Rs = 5'd3;
        tick(); check_val("lu_rt_end", out_a, ORun);
        tick(); check_val("no_load", out_a, ORun);
        idle();

        // Taken branch: 2 cycles on dut2, 4 on dut4
        BranchTaken = 1'b1;
        tick(); check_val("br2_c0", out_a, OBfl); check_val("br4_c0", out_b, OBfl);
        BranchTaken = 1'b0;
        tick(); check_val("br2_c1", out_a, OBfl); check_val("br4_c1", out_b, OBfl);
        tick(); check_val("br2_c2", out_a, ORun); check_val("br4_c2", out_b, OBfl);
        tick(); check_val("br4_c3", out_b, OBfl);
        tick(); check_val("br4_c4", out_b, ORun);

        // Jump during first BFLUSH cycle is ignored
        BranchTaken = 1'b1;
        tick(); check_val("bj_c0", out_a, OBfl);
        BranchTaken = 1'b0; Jump = 1'b1;
        tick(); check_val("bj_c1", out_a, OBfl);
        Jump = 1'b0;
        tick(); check_val("bj_c2", out_a, ORun);
        tick(); check_val("bj_b_c3", out_b, OBfl);
        tick(); check_val("bj_b_done", out_b, ORun);

        // Exception preempts branch flush
        BranchTaken = 1'b1;
        tick(); check_val("ex_c0", out_a, OBfl);
        BranchTaken = 1'b0; Exception = 1'b1;
        tick(); check_val("ex_c1_a", out_a, OExc); check_val("ex_c1_b", out_b, OExc);
        Exception = 1'b0;
        tick(); check_val("ex_c2_a", out_a, ORun); check_val("ex_c2_b", out_b, ORun);

        // Branch beats load-use
        BranchTaken = 1'b1; EX_MemRead = 1'b1; EX_Rt = 5'd8; ID_Rs = 5'd8;
        tick(); check_val("bl_c0", out_a, OBfl);
        idle();
        tick(); check_val("bl_c1", out_a, OBfl);
        tick(); check_val("bl_c2", out_a, ORun);

        // Plain jump
        Jump = 1'b1;
        tick(); check_val("jmp_c0", out_a, OJfl);
        Jump = 1'b0;
        tick(); check_val("jmp_c1", out_a, ORun);
        tick(); tick();

        // Async reset in the middle of a branch flush
        BranchTaken = 1'b1;
        tick(); check_val("rst_pre", out_b, OBfl);
        BranchTaken = 1'b0;
        #2 Reset = 1'b1;
        #1;
        check_val("rst_async_a", out_a, ORun);
        check_val("rst_async_b", out_b, ORun);
        @(negedge clk);
        Reset = 1'b0;
        tick(); check_val("rst_rel_a", out_a, ORun); check_val("rst_rel_b", out_b, ORun);
        tick(); check_val("rst_rel2_b", out_b, ORun);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
